mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 192 +++++++++++++++++++
 tb/tb_mem_stage.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage -- memory stage of the five-stage pipeline.
//
// Issues data-cache requests for the instruction sitting in EX/MEM, stalls the
// pipeline until the cache reports dhit, resolves jumps/branches into a fetch
// redirect and loads the MEM/WB register. A captured halt parks the stage in
// HALT until reset.
//
// Ports
//   CLK, RST               clock, synchronous active-high reset
//   ex_valid               EX/MEM holds a live instruction
//   alu_out, rdat2         data address / store data
//   rdat1, Jaddr           jr target / jump target
//   extout, npc            branch immediate / PC+4
//   DRen..halt, Mem, wsel  EX/MEM control fields
//   dmemREN, dmemWEN       cache read/write request
//   dmemaddr, dmemstore    cache address / store data
//   dhit, dmemload         cache completion / load data
//   mem_stall              freezes PC, IF/ID, ID/EX, EX/MEM
//   pc_redir, pc_target    fetch redirect and its target
//   wb_*                   MEM/WB register
//   mem_timeout            (only with MEM_STAGE_TIMEOUT_EN) sticky flag set
//                          after 255 consecutive WAIT cycles
//
// Build option: define MEM_STAGE_TIMEOUT_EN to add the wait-cycle counter and
// the mem_timeout output.
// -----------------------------------------------------------------------------
module mem_stage #(
   parameter int DATA_W = 32
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              ex_valid,
   input  logic [DATA_W-1:0] alu_out,
   input  logic [DATA_W-1:0] rdat2,
   input  logic [DATA_W-1:0] rdat1,
   input  logic [DATA_W-1:0] extout,
   input  logic [DATA_W-1:0] npc,
   input  logic [DATA_W-1:0] Jaddr,
   input  logic              DRen,
   input  logic              DWen,
   input  logic              RegW,
   input  logic              Branch,
   input  logic              BNE,
   input  logic              jump,
   input  logic              jr,
   input  logic              zero,
   input  logic              halt,
   input  logic [1:0]        Mem,
   input  logic [4:0]        wsel,
   output logic              dmemREN,
   output logic              dmemWEN,
   output logic [DATA_W-1:0] dmemaddr,
   output logic [DATA_W-1:0] dmemstore,
   input  logic              dhit,
   input  logic [DATA_W-1:0] dmemload,
   output logic              mem_stall,
   output logic              pc_redir,
   output logic [DATA_W-1:0] pc_target,
`ifdef MEM_STAGE_TIMEOUT_EN
   output logic              mem_timeout,
`endif
   output logic              wb_valid,
   output logic              wb_RegW,
   output logic              wb_halt,
   output logic [4:0]        wb_wsel,
   output logic [DATA_W-1:0] wb_wdat
);

   typedef enum logic [1:0] {
      S_RUN  = 2'd0,
      S_WAIT = 2'd1,
      S_HALT = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic                     memop;
   logic                     is_store;
   logic                     redir_ok;
   logic                     br_taken;
   logic signed [DATA_W-1:0] br_off;
   logic        [DATA_W-1:0] br_tgt;
   logic        [DATA_W-1:0] wdat_sel;

   // ---- request / stall / redirect (combinational from EX/MEM) ----
   always_comb begin
      memop     = ex_valid & (DRen | DWen) & (state != S_HALT) & ~RST;
      dmemREN   = memop & DRen;
      dmemWEN   = memop & DWen & ~DRen;
      dmemaddr  = alu_out;
      dmemstore = rdat2;
      mem_stall = memop & ~dhit;
      is_store  = DWen & ~DRen;

      // Word offset, sign kept; the add wraps modulo 2^32.
      br_off    = $signed(extout) <<< 2;
      br_tgt    = $unsigned($signed(npc) + br_off);
      br_taken  = Branch & (zero ^ BNE);

      // A redirect from an instruction still waiting on the cache is held
      // back until its dhit cycle, so it fires exactly once.
      redir_ok  = ex_valid & ~mem_stall & (state != S_HALT) & ~RST;
      pc_redir  = 1'b0;
      pc_target = '0;
      if (redir_ok) begin
         if (jr) begin
            pc_redir  = 1'b1;
            pc_target = rdat1;
         end else if (jump) begin
            pc_redir  = 1'b1;
            pc_target = Jaddr;
         end else if (br_taken) begin
            pc_redir  = 1'b1;
            pc_target = br_tgt;
         end
      end

      // Mem = 11 is reserved and falls back to the ALU result.
      case (Mem)
         2'b01:   wdat_sel = dmemload;
         2'b10:   wdat_sel = npc;
         default: wdat_sel = alu_out;
      endcase
   end

   // ---- FSM next state ----
   always_comb begin
      state_nxt = state;
      case (state)
         S_RUN, S_WAIT: begin
            if (ex_valid & halt & ~mem_stall)
               state_nxt = S_HALT;
            else if (mem_stall)
               state_nxt = S_WAIT;
            else
               state_nxt = S_RUN;
         end
         S_HALT:  state_nxt = S_HALT;
         default: state_nxt = S_RUN;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) state <= S_RUN;
      else     state <= state_nxt;
   end

   // ---- MEM/WB register boundary ----
   always_ff @(posedge CLK) begin
      if (RST) begin
         wb_valid <= 1'b0;
         wb_RegW  <= 1'b0;
         wb_halt  <= 1'b0;
         wb_wsel  <= '0;
         wb_wdat  <= '0;
      end else if (state == S_HALT) begin
         wb_valid <= 1'b0;
         wb_RegW  <= 1'b0;
         wb_halt  <= 1'b1;
      end else if (mem_stall) begin
         wb_valid <= 1'b0;
         wb_RegW  <= 1'b0;
         wb_halt  <= 1'b0;
      end else begin
         wb_valid <= ex_valid;
         wb_RegW  <= ex_valid & RegW & ~is_store;
         wb_halt  <= ex_valid & halt;
         wb_wsel  <= wsel;
         wb_wdat  <= wdat_sel;
      end
   end

`ifdef MEM_STAGE_TIMEOUT_EN
   logic [7:0] wait_cnt;

   // Saturating count of WAIT cycles; the flag latches once the count hits
   // 255 and only reset clears it.
   always_ff @(posedge CLK) begin
      if (RST) begin
         wait_cnt    <= '0;
         mem_timeout <= 1'b0;
      end else if (state == S_WAIT) begin
         if (wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
         if (wait_cnt >= 8'hFE) mem_timeout <= 1'b1;
      end else begin
         wait_cnt <= '0;
      end
   end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage -- directed bench for mem_stage: a table of single-cycle
// vectors followed by hand-written multi-cycle sequences (load wait, reset in
// WAIT, halt, optional timeout).
// -----------------------------------------------------------------------------
module tb_mem_stage;

   logic        CLK = 1'b0;
   logic        RST;
   logic        ex_valid;
   logic [31:0] alu_out, rdat2, rdat1, extout, npc, Jaddr, dmemload;
   logic        DRen, DWen, RegW, Branch, BNE, jump, jr, zero, halt, dhit;
   logic [1:0]  Mem;
   logic [4:0]  wsel;
   logic        dmemREN, dmemWEN, mem_stall, pc_redir;
   logic [31:0] dmemaddr, dmemstore, pc_target, wb_wdat;
   logic        wb_valid, wb_RegW, wb_halt;
   logic [4:0]  wb_wsel;
`ifdef MEM_STAGE_TIMEOUT_EN
   logic        mem_timeout;
`endif

   int total = 0;
   int bad   = 0;

   always #5 CLK = ~CLK;

   mem_stage dut (
      .CLK(CLK), .RST(RST), .ex_valid(ex_valid),
      .alu_out(alu_out), .rdat2(rdat2), .rdat1(rdat1), .extout(extout),
      .npc(npc), .Jaddr(Jaddr),
      .DRen(DRen), .DWen(DWen), .RegW(RegW), .Branch(Branch), .BNE(BNE),
      .jump(jump), .jr(jr), .zero(zero), .halt(halt),
      .Mem(Mem), .wsel(wsel),
      .dmemREN(dmemREN), .dmemWEN(dmemWEN),
      .dmemaddr(dmemaddr), .dmemstore(dmemstore),
      .dhit(dhit), .dmemload(dmemload),
      .mem_stall(mem_stall), .pc_redir(pc_redir), .pc_target(pc_target),
`ifdef MEM_STAGE_TIMEOUT_EN
      .mem_timeout(mem_timeout),
`endif
      .wb_valid(wb_valid), .wb_RegW(wb_RegW), .wb_halt(wb_halt),
      .wb_wsel(wb_wsel), .wb_wdat(wb_wdat)
   );

   typedef struct {
      logic        ex_valid, DRen, DWen, RegW, Branch, BNE, jump, jr, zero, halt, dhit;
      logic [1:0]  Mem;
      logic [4:0]  wsel;
      logic [31:0] alu_out, rdat1, rdat2, extout, npc, Jaddr, dmemload;
      logic        e_ren, e_wen, e_stall, e_redir, e_wbv, e_wbr;
      logic [31:0] e_tgt, e_wdat;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic vec_t dflt();
      vec_t v;
      v.ex_valid = 1'b1; v.DRen = 1'b0; v.DWen = 1'b0; v.RegW = 1'b0;
      v.Branch = 1'b0; v.BNE = 1'b0; v.jump = 1'b0; v.jr = 1'b0;
      v.zero = 1'b0; v.halt = 1'b0; v.dhit = 1'b1; v.Mem = 2'b00; v.wsel = 5'd0;
      v.alu_out = '0; v.rdat1 = '0; v.rdat2 = '0; v.extout = '0;
      v.npc = '0; v.Jaddr = '0; v.dmemload = '0;
      v.e_ren = 1'b0; v.e_wen = 1'b0; v.e_stall = 1'b0; v.e_redir = 1'b0;
      v.e_wbv = 1'b1; v.e_wbr = 1'b0; v.e_tgt = '0; v.e_wdat = '0;
      return v;
   endfunction

   task automatic apply(input vec_t v);
      ex_valid = v.ex_valid; DRen = v.DRen; DWen = v.DWen; RegW = v.RegW;
      Branch = v.Branch; BNE = v.BNE; jump = v.jump; jr = v.jr; zero = v.zero;
      halt = v.halt; dhit = v.dhit; Mem = v.Mem; wsel = v.wsel;
      alu_out = v.alu_out; rdat1 = v.rdat1; rdat2 = v.rdat2; extout = v.extout;
      npc = v.npc; Jaddr = v.Jaddr; dmemload = v.dmemload;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      vec_t v;

      // ---- vector table ----
      v = dflt(); v.RegW = 1; v.wsel = 5; v.alu_out = 32'h11;
      v.e_wbr = 1; v.e_wdat = 32'h11; tbl.push_back(v);
      v = dflt(); v.DWen = 1; v.RegW = 1; v.wsel = 6; v.alu_out = 32'h200; v.rdat2 = 32'h12345678;
      v.e_wen = 1; v.e_wdat = 32'h200; tbl.push_back(v);
      v = dflt(); v.DRen = 1; v.RegW = 1; v.Mem = 2'b01; v.wsel = 7; v.alu_out = 32'h104;
      v.dmemload = 32'hCAFEF00D; v.e_ren = 1; v.e_wbr = 1; v.e_wdat = 32'hCAFEF00D; tbl.push_back(v);
      v = dflt(); v.Branch = 1; v.zero = 1; v.npc = 32'h40; v.extout = 32'hFFFFFFFF; v.alu_out = 32'h99;
      v.e_redir = 1; v.e_tgt = 32'h3C; v.e_wdat = 32'h99; tbl.push_back(v);
      v = dflt(); v.Branch = 1; v.BNE = 1; v.zero = 1; v.npc = 32'h40; v.extout = 32'hFFFFFFFF;
      v.alu_out = 32'h99; v.e_wdat = 32'h99; tbl.push_back(v);
      v = dflt(); v.jr = 1; v.jump = 1; v.Branch = 1; v.zero = 1; v.rdat1 = 32'h1000;
      v.Jaddr = 32'h2000; v.npc = 32'h40; v.extout = 32'h1; v.e_redir = 1; v.e_tgt = 32'h1000; tbl.push_back(v);
      v = dflt(); v.jump = 1; v.Branch = 1; v.zero = 1; v.rdat1 = 32'h1000;
      v.Jaddr = 32'h2000; v.npc = 32'h40; v.extout = 32'h1; v.e_redir = 1; v.e_tgt = 32'h2000; tbl.push_back(v);
      v = dflt(); v.RegW = 1; v.Mem = 2'b10; v.wsel = 31; v.npc = 32'h88; v.alu_out = 32'h55;
      v.e_wbr = 1; v.e_wdat = 32'h88; tbl.push_back(v);
      v = dflt(); v.RegW = 1; v.Mem = 2'b11; v.wsel = 3; v.npc = 32'h88; v.alu_out = 32'h55;
      v.e_wbr = 1; v.e_wdat = 32'h55; tbl.push_back(v);
      v = dflt(); v.ex_valid = 0; v.RegW = 1; v.jump = 1; v.DRen = 1; v.Jaddr = 32'h2000;
      v.wsel = 9; v.alu_out = 32'h77; v.e_wbv = 0; v.e_wdat = 32'h77; tbl.push_back(v);
      v = dflt(); v.DRen = 1; v.DWen = 1; v.RegW = 1; v.Mem = 2'b01; v.wsel = 4;
      v.dmemload = 32'h0BADF00D; v.e_ren = 1; v.e_wbr = 1; v.e_wdat = 32'h0BADF00D; tbl.push_back(v);
      v = dflt(); v.Branch = 1; v.BNE = 1; v.zero = 0; v.npc = 32'h100; v.extout = 32'h4;
      v.e_redir = 1; v.e_tgt = 32'h110; tbl.push_back(v);
      v = dflt(); v.Branch = 1; v.zero = 1; v.npc = 32'hFFFFFFFC; v.extout = 32'h1;
      v.e_redir = 1; v.e_tgt = 32'h0; tbl.push_back(v);

      // ---- reset: requests forced low even with a load presented ----
      v = dflt(); v.DRen = 1; v.dhit = 0; v.Jaddr = 32'h44; v.jump = 1;
      apply(v);
      RST = 1'b1;
      tick(); tick();
      chk("rst_ren", {31'd0, dmemREN}, 0);
      chk("rst_stall", {31'd0, mem_stall}, 0);
      chk("rst_redir", {31'd0, pc_redir}, 0);
      chk("rst_wbv", {31'd0, wb_valid}, 0);
      chk("rst_wbr", {31'd0, wb_RegW}, 0);
      chk("rst_halt", {31'd0, wb_halt}, 0);
      chk("rst_wsel", {27'd0, wb_wsel}, 0);
      chk("rst_wdat", wb_wdat, 0);
      RST = 1'b0;

      // ---- table ----
      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i]);
         #1;
         chk($sformatf("v%0d_ren", i), {31'd0, dmemREN}, {31'd0, tbl[i].e_ren});
         chk($sformatf("v%0d_wen", i), {31'd0, dmemWEN}, {31'd0, tbl[i].e_wen});
         chk($sformatf("v%0d_stall", i), {31'd0, mem_stall}, {31'd0, tbl[i].e_stall});
         chk($sformatf("v%0d_redir", i), {31'd0, pc_redir}, {31'd0, tbl[i].e_redir});
         chk($sformatf("v%0d_tgt", i), pc_target, tbl[i].e_tgt);
         chk($sformatf("v%0d_addr", i), dmemaddr, tbl[i].alu_out);
         chk($sformatf("v%0d_store", i), dmemstore, tbl[i].rdat2);
         tick();
         chk($sformatf("v%0d_wbv", i), {31'd0, wb_valid}, {31'd0, tbl[i].e_wbv});
         chk($sformatf("v%0d_wbr", i), {31'd0, wb_RegW}, {31'd0, tbl[i].e_wbr});
         chk($sformatf("v%0d_wsel", i), {27'd0, wb_wsel}, {27'd0, tbl[i].wsel});
         chk($sformatf("v%0d_wdat", i), wb_wdat, tbl[i].e_wdat);
         chk($sformatf("v%0d_whalt", i), {31'd0, wb_halt}, 0);
      end

      // ---- load with three wait cycles; its jump is held until dhit ----
      v = dflt(); v.DRen = 1; v.RegW = 1; v.Mem = 2'b01; v.wsel = 9; v.alu_out = 32'h100;
      v.jump = 1; v.Jaddr = 32'h3000; v.dhit = 0;
      apply(v);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("lw_stall%0d", k), {31'd0, mem_stall}, 1);
         chk($sformatf("lw_ren%0d", k), {31'd0, dmemREN}, 1);
         chk($sformatf("lw_redir%0d", k), {31'd0, pc_redir}, 0);
         tick();
         chk($sformatf("lw_bub_v%0d", k), {31'd0, wb_valid}, 0);
         chk($sformatf("lw_bub_r%0d", k), {31'd0, wb_RegW}, 0);
      end
      dhit = 1; dmemload = 32'hDEADBEEF;
      #1;
      chk("lw_hit_stall", {31'd0, mem_stall}, 0);
      chk("lw_hit_redir", {31'd0, pc_redir}, 1);
      chk("lw_hit_tgt", pc_target, 32'h3000);
      tick();
      chk("lw_wbv", {31'd0, wb_valid}, 1);
      chk("lw_wbr", {31'd0, wb_RegW}, 1);
      chk("lw_wdat", wb_wdat, 32'hDEADBEEF);
      ex_valid = 0; dhit = 0;
      tick();
      chk("lw_once", {31'd0, wb_valid}, 0);

      // ---- reset during the second WAIT cycle ----
      v = dflt(); v.DRen = 1; v.RegW = 1; v.Mem = 2'b01; v.wsel = 12; v.alu_out = 32'h300; v.dhit = 0;
      apply(v);
      tick();
      tick();
      RST = 1;
      #1;
      chk("rw_ren", {31'd0, dmemREN}, 0);
      chk("rw_stall", {31'd0, mem_stall}, 0);
      tick();
      RST = 0; ex_valid = 0;
      #1;
      chk("rw_wbv", {31'd0, wb_valid}, 0);
      chk("rw_wbr", {31'd0, wb_RegW}, 0);
      chk("rw_wdat", wb_wdat, 0);
      chk("rw_ren2", {31'd0, dmemREN}, 0);
      v = dflt(); v.RegW = 1; v.wsel = 2; v.alu_out = 32'hABC;
      apply(v);
      tick();
      chk("rw_after_v", {31'd0, wb_valid}, 1);
      chk("rw_after_d", wb_wdat, 32'hABC);

      // ---- halt is sticky until reset ----
      v = dflt(); v.halt = 1; v.alu_out = 32'h5;
      apply(v);
      tick();
      chk("h_cap_v", {31'd0, wb_valid}, 1);
      chk("h_cap_h", {31'd0, wb_halt}, 1);
      v = dflt(); v.DRen = 1; v.RegW = 1; v.jump = 1; v.Jaddr = 32'h80; v.dhit = 0;
      apply(v);
      #1;
      chk("h_ren", {31'd0, dmemREN}, 0);
      chk("h_stall", {31'd0, mem_stall}, 0);
      chk("h_redir", {31'd0, pc_redir}, 0);
      tick();
      chk("h_wbv", {31'd0, wb_valid}, 0);
      chk("h_halt1", {31'd0, wb_halt}, 1);
      tick();
      chk("h_halt2", {31'd0, wb_halt}, 1);
      chk("h_ren2", {31'd0, dmemREN}, 0);
      RST = 1;
      tick();
      RST = 0;
      chk("h_rst", {31'd0, wb_halt}, 0);
      #1;
      chk("h_rst_ren", {31'd0, dmemREN}, 1);

`ifdef MEM_STAGE_TIMEOUT_EN
      // ---- cache never answers: timeout flag ----
      dhit = 0;
      chk("to_init", {31'd0, mem_timeout}, 0);
      repeat (200) tick();
      chk("to_early", {31'd0, mem_timeout}, 0);
      chk("to_stall", {31'd0, mem_stall}, 1);
      repeat (60) tick();
      chk("to_set", {31'd0, mem_timeout}, 1);
      chk("to_stall2", {31'd0, mem_stall}, 1);
      dhit = 1;
      tick();
      ex_valid = 0;
      tick();
      chk("to_sticky", {31'd0, mem_timeout}, 1);
      RST = 1;
      tick();
      RST = 0;
      chk("to_rst", {31'd0, mem_timeout}, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
